// File: rtl/huff_encoder.sv
`default_nettype none
// ============================================================================
// Module      : huff_encoder
// Description : Huffman encoder with a loadable codebook. Symbols are mapped
//               to left-aligned variable-length codes, which are packed
//               MSB-first into 32-bit words on a valid/ready stream.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cb_data    in   codebook entry {len, sym, code}, code left-aligned
//   cb_valid   in   codebook entry valid
//   cb_ready   out  codebook entry accepted (IDLE only)
//   start      in   pulse, IDLE -> ENCODE, clears err
//   flush      in   pulse in ENCODE, drain and terminate the stream
//   sym_in     in   input symbol
//   sym_valid  in   symbol valid
//   sym_ready  out  symbol accepted
//   data_out   out  packed code word, first code bit at MSB
//   out_valid  out  data_out valid, held until out_ready
//   out_ready  in   downstream accepts word
//   out_bits   out  valid bits in data_out
//   out_last   out  final word of the stream
//   busy       out  encoder not idle
//   err        out  sticky error flag
// ============================================================================
module huff_encoder #(
  parameter int SYM_W  = 5,
  parameter int LEN_W  = 6,
  parameter int CODE_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LEN_W+SYM_W+CODE_W-1:0]   cb_data,
  input  logic                            cb_valid,
  output logic                            cb_ready,
  input  logic                            start,
  input  logic                            flush,
  input  logic [SYM_W-1:0]                sym_in,
  input  logic                            sym_valid,
  output logic                            sym_ready,
  output logic [CODE_W-1:0]               data_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LEN_W-1:0]                out_bits,
  output logic                            out_last,
  output logic                            busy,
  output logic                            err
);

  localparam int DEPTH  = 1 << SYM_W;
  localparam int ACC_W  = 2 * CODE_W;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] c_word_fill = FILL_W'(CODE_W);
  localparam logic [LEN_W-1:0]  c_word_len  = LEN_W'(CODE_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DEPTH-1:0]    r_tbl_vld;
  logic [LEN_W-1:0]    r_tbl_len  [DEPTH];
  logic [CODE_W-1:0]   r_tbl_code [DEPTH];

  logic [ACC_W-1:0]    r_acc;
  logic [FILL_W-1:0]   r_fill;
  logic                r_err;

  // --------------------------------------------------------------------------
  // Codebook load path
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0]    w_cb_len;
  logic [SYM_W-1:0]    w_cb_sym;
  logic [CODE_W-1:0]   w_cb_code;
  logic                w_cb_len_ok;
  logic                w_cb_fire;

  assign w_cb_len    = cb_data[LEN_W+SYM_W+CODE_W-1 -: LEN_W];
  assign w_cb_sym    = cb_data[SYM_W+CODE_W-1 -: SYM_W];
  assign w_cb_code   = cb_data[CODE_W-1:0];
  assign w_cb_len_ok = (w_cb_len != '0) && (w_cb_len <= c_word_len);
  // start takes priority: an entry offered in the same cycle is not written.
  assign w_cb_fire   = (r_state == S_IDLE) && cb_valid && !start;

  assign cb_ready    = (r_state == S_IDLE);

  // --------------------------------------------------------------------------
  // Output word and emit
  // --------------------------------------------------------------------------
  logic                w_full_word;
  logic                w_emit;
  logic [FILL_W-1:0]   w_fill_post;
  logic [ACC_W-1:0]    w_acc_post;

  assign w_full_word = (r_fill >= c_word_fill);

  assign out_valid = ((r_state == S_ENCODE) && w_full_word) ||
                     ((r_state == S_FLUSH)  && (r_fill != '0));
  // Bits below the fill point are always zero, so a partial word is
  // implicitly zero-padded.
  assign data_out  = r_acc[ACC_W-1 -: CODE_W];
  assign out_bits  = !out_valid  ? '0 :
                     w_full_word ? c_word_len : r_fill[LEN_W-1:0];
  assign out_last  = (r_state == S_FLUSH) && (r_fill != '0) &&
                     (r_fill <= c_word_fill);

  assign w_emit      = out_valid && out_ready;
  // Shift happens before any same-cycle insert.
  assign w_fill_post = !w_emit     ? r_fill :
                       w_full_word ? (r_fill - c_word_fill) : '0;
  assign w_acc_post  = w_emit ? (r_acc << CODE_W) : r_acc;

  // --------------------------------------------------------------------------
  // Symbol insert path
  // --------------------------------------------------------------------------
  logic                w_sym_fire;
  logic                w_sym_hit;
  logic [LEN_W-1:0]    w_sym_len;
  logic [CODE_W-1:0]   w_code_mask;
  logic [ACC_W-1:0]    w_ins;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic                w_err_nxt;

  // Room for a full-length code after any emit in this cycle.
  assign sym_ready   = (r_state == S_ENCODE) && (w_fill_post <= c_word_fill);
  assign w_sym_fire  = sym_valid && sym_ready;
  assign w_sym_hit   = r_tbl_vld[sym_in];
  assign w_sym_len   = r_tbl_len[sym_in];
  // Keeps the top len bits of the stored code; len is always 1..CODE_W.
  assign w_code_mask = ~({CODE_W{1'b1}} >> w_sym_len);
  assign w_ins       = {r_tbl_code[sym_in] & w_code_mask, {CODE_W{1'b0}}} >> w_fill_post;

  always_comb begin
    w_acc_nxt  = w_acc_post;
    w_fill_nxt = w_fill_post;
    if (w_sym_fire && w_sym_hit) begin
      w_acc_nxt  = w_acc_post | w_ins;
      w_fill_nxt = w_fill_post + FILL_W'(w_sym_len);
    end
  end

  always_comb begin
    w_err_nxt = start ? 1'b0 : r_err;
    if (w_cb_fire && !w_cb_len_ok) begin
      w_err_nxt = 1'b1;
    end
    if (w_sym_fire && !w_sym_hit) begin
      w_err_nxt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ENCODE;
        end
      end
      S_ENCODE: begin
        if (flush) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (r_fill == '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_emit && out_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and codebook storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_fill <= '0;
      r_err  <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      r_err  <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tbl_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tbl_len[i]  <= '0;
        r_tbl_code[i] <= '0;
      end
    end else if (w_cb_fire && w_cb_len_ok) begin
      r_tbl_vld[w_cb_sym]  <= 1'b1;
      r_tbl_len[w_cb_sym]  <= w_cb_len;
      r_tbl_code[w_cb_sym] <= w_cb_code;
    end
  end

  assign busy = (r_state != S_IDLE);
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_huff_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_huff_encoder
// Description : Self-checking bench for huff_encoder. A bit-queue reference
//               model tracks the stream; every cycle the DUT handshakes,
//               status and emitted words are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [42:0] cb_data = '0;
  logic        cb_valid = 1'b0;
  logic        cb_ready;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  sym_in = '0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [31:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_bits;
  logic        out_last;
  logic        busy;
  logic        err;

  huff_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .cb_data   (cb_data),
    .cb_valid  (cb_valid),
    .cb_ready  (cb_ready),
    .start     (start),
    .flush     (flush),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: codebook, pending bit stream, mode (0 idle, 1 encode, 2 flush)
  bit          m_vld  [32];
  int          m_len  [32];
  logic [31:0] m_code [32];
  bit          q[$];
  int          m_state = 0;
  bit          m_err = 1'b0;
  bit          m_sym_acc = 1'b0;

  logic [31:0] last_word = '0;
  int          last_bits = 0;
  bit          last_last = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_vld[i]  = 1'b0;
      m_len[i]  = 0;
      m_code[i] = '0;
    end
    q.delete();
    m_state = 0;
    m_err   = 1'b0;
  endtask

  // One clock: compare at negedge, advance model, return at posedge+1.
  task automatic tick();
    int          sz;
    int          exp_bits;
    int          len;
    int          s;
    bit          exp_ov;
    bit          exp_sr;
    bit          exp_last;
    bit          emit;
    bit          go_idle;
    bit          new_err;
    logic [31:0] w;
    @(negedge clk);
    sz       = q.size();
    exp_ov   = (m_state == 1 && sz >= 32) || (m_state == 2 && sz > 0);
    exp_bits = (sz >= 32) ? 32 : sz;
    exp_last = (m_state == 2) && (sz > 0) && (sz <= 32);
    emit     = exp_ov && out_ready;
    exp_sr   = (m_state == 1) && ((sz - (emit ? 32 : 0)) <= 32);
    chk("busy",      busy,      m_state != 0);
    chk("err",       err,       m_err);
    chk("cb_ready",  cb_ready,  m_state == 0);
    chk("sym_ready", sym_ready, exp_sr);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      w = '0;
      for (int i = 0; i < exp_bits; i++) w[31-i] = q[i];
      chk("data_out", data_out, w);
      chk("out_bits", out_bits, exp_bits);
      chk("out_last", out_last, exp_last);
      if (emit) begin
        last_word = data_out;
        last_bits = out_bits;
        last_last = out_last;
        repeat (exp_bits) void'(q.pop_front());
      end
    end
    go_idle = (m_state == 2) && (sz == 0 || (emit && exp_last));
    new_err = start ? 1'b0 : m_err;
    if (m_state == 0 && cb_valid && !start) begin
      len = int'(cb_data[42:37]);
      s   = int'(cb_data[36:32]);
      if (len >= 1 && len <= 32) begin
        m_vld[s]  = 1'b1;
        m_len[s]  = len;
        m_code[s] = cb_data[31:0];
      end else begin
        new_err = 1'b1;
      end
    end
    m_sym_acc = sym_valid && exp_sr;
    if (m_sym_acc) begin
      if (m_vld[sym_in]) begin
        for (int i = 0; i < m_len[sym_in]; i++) q.push_back(m_code[sym_in][31-i]);
      end else begin
        new_err = 1'b1;
      end
    end
    m_err = new_err;
    if (m_state == 0 && start)      m_state = 1;
    else if (m_state == 1 && flush) m_state = 2;
    else if (go_idle)               m_state = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    chk("rst_cb_ready",  cb_ready,  1'b1);
    chk("rst_sym_ready", sym_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out",  data_out,  32'h0);
    chk("rst_out_bits",  out_bits,  6'd0);
    chk("rst_out_last",  out_last,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_err",       err,       1'b0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load(input logic [4:0] s, input logic [5:0] len, input logic [31:0] code);
    cb_data  = {len, s, code};
    cb_valid = 1'b1;
    tick();
    cb_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] s);
    bit done;
    done      = 1'b0;
    sym_in    = s;
    sym_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      done = m_sym_acc;
    end
    sym_valid = 1'b0;
    chk("send_timeout", done, 1'b1);
  endtask

  task automatic flush_and_wait();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 200 && m_state != 0; k++) tick();
    chk("flush_done", busy, 1'b0);
  endtask

  task automatic load_basic();
    load(5'd1, 6'd2, 32'h0000_0000);
    load(5'd2, 6'd2, 32'h4000_0000);
    load(5'd3, 6'd3, 32'h8000_0000);
    load(5'd4, 6'd3, 32'hA000_0000);
    load(5'd5, 6'd4, 32'hC000_0000);
    load(5'd6, 6'd4, 32'hD000_0000);
    load(5'd7, 6'd5, 32'hE000_0000);
    load(5'd8, 6'd5, 32'hE800_0000);
    load(5'd9, 6'd4, 32'hF000_0000);
  endtask

  task automatic random_traffic(input int cycles, input int max_sym);
    for (int k = 0; k < cycles; k++) begin
      sym_valid = ($urandom_range(0, 3) != 0);
      sym_in    = 5'($urandom_range(0, max_sym));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    sym_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    model_clear();
    apply_reset();

    // Nine-symbol message forming exactly one word
    load_basic();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 9; i++) send(5'(i));
    tick();
    tick();
    chk("t1_word", last_word, 32'h197379DF);
    chk("t1_bits", last_bits, 32);
    chk("t1_last", last_last, 1'b0);
    flush_and_wait();

    // Short message with padded last word
    pulse_start();
    send(5'd1);
    send(5'd3);
    flush_and_wait();
    chk("t2_word", last_word, 32'h2000_0000);
    chk("t2_bits", last_bits, 5);
    chk("t2_last", last_last, 1'b1);
    chk("t2_busy", busy, 1'b0);

    // Backpressure: fill past one word, then random traffic
    out_ready = 1'b0;
    pulse_start();
    sym_in    = 5'd7;
    sym_valid = 1'b1;
    repeat (12) tick();
    sym_valid = 1'b0;
    chk("t3_sym_ready_low", sym_ready, 1'b0);
    chk("t3_out_valid",     out_valid, 1'b1);
    out_ready = 1'b1;
    random_traffic(300, 9);
    flush_and_wait();

    // Unloaded symbol
    pulse_start();
    send(5'd0);
    tick();
    chk("t4_err", err, 1'b1);
    flush_and_wait();
    pulse_start();
    chk("t4_err_clr", err, 1'b0);
    flush_and_wait();

    // Illegal codebook lengths
    load(5'd10, 6'd33, 32'hFFFF_FFFF);
    load(5'd11, 6'd0,  32'h8000_0000);
    chk("t5_err", err, 1'b1);
    pulse_start();
    send(5'd10);
    tick();
    chk("t5_enc_err10", err, 1'b1);
    flush_and_wait();
    pulse_start();
    send(5'd11);
    tick();
    chk("t5_enc_err11", err, 1'b1);
    flush_and_wait();

    // start wins over a same-cycle codebook write
    cb_data  = {6'd3, 5'd12, 32'h2000_0000};
    cb_valid = 1'b1;
    start    = 1'b1;
    tick();
    cb_valid = 1'b0;
    start    = 1'b0;
    chk("sw_err_clr", err, 1'b0);
    send(5'd12);
    tick();
    chk("sw_err", err, 1'b1);
    flush_and_wait();

    // Reset mid-encode with 20 bits pending
    pulse_start();
    repeat (4) send(5'd7);
    apply_reset();
    pulse_start();
    send(5'd1);
    tick();
    chk("t6_err", err, 1'b1);
    flush_and_wait();

    // Fully random codebook including long codes
    for (int i = 0; i < 32; i++) load(5'(i), 6'($urandom_range(1, 32)), $urandom);
    pulse_start();
    random_traffic(600, 31);
    flush_and_wait();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
